// File: rtl/dac_adc_pkg.sv
// Shared definitions for the DAC SPI transmitter: frame layout, default
// control bits and the transmitter FSM encoding.
package dac_adc_pkg;

    localparam int         FRAME_W          = 16;
    localparam int         CODE_W           = 12;
    localparam logic [3:0] CFG_BITS_DEFAULT = 4'b0111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } tx_state_e;

    // Control nibble goes out first, followed by the DAC code, MSB first.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]        cfg,
                                                       input logic [CODE_W-1:0] code);
        return {cfg, code};
    endfunction

endpackage

// File: rtl/spi_clk_en.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles while en_i
// is high; the count is held at zero whenever en_i is low.
module spi_clk_en #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || cnt_q == TERM) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for a 12-bit DAC: sends {CFG_BITS, data_i} as one
// 16-bit frame framed by cs_n_o, with all outputs registered.
module dac_spi_tx
    import dac_adc_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter logic [3:0] CFG_BITS = CFG_BITS_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CODE_W-1:0] data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cs_n_o,
    output logic              sclk_o,
    output logic              mosi_o
);

    tx_state_e          state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               cs_n_q, cs_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tick;
    logic               tick_en;

    // Every timed state ends on a tick, so the divider wraps to zero exactly
    // on each state entry and needs no separate clear.
    assign tick_en = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

    spi_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (tick_en),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shreg_d = build_frame(CFG_BITS, data_i);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sclk_d = sclk_q;
                if (tick) begin
                    sclk_d = ~sclk_q;
                    // The next bit is presented only on the falling edge.
                    if (sclk_q) begin
                        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                        if (bit_cnt_q == 5'd15) begin
                            bit_cnt_d = 5'd0;
                            state_d   = HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        cs_n_d = (state_d == IDLE) || (state_d == DONE);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        mosi_d = cs_n_d ? 1'b0 : shreg_d[FRAME_W-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= 5'd0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign cs_n_o = cs_n_q;
    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: a table of frames on H=4 and H=2 instances
// plus hand-written reset and start/reset collision sequences.
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0;
    logic        start2 = 1'b0;
    logic [11:0] data_i = 12'h000;

    logic busy4, done4, cs4, sclk4, mosi4;
    logic busy2, done2, cs2, sclk2, mosi2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_spi_tx #(.CLK_DIV(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .data_i(data_i),
        .busy_o(busy4), .done_o(done4), .cs_n_o(cs4), .sclk_o(sclk4), .mosi_o(mosi4)
    );

    dac_spi_tx #(.CLK_DIV(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .data_i(data_i),
        .busy_o(busy2), .done_o(done2), .cs_n_o(cs2), .sclk_o(sclk2), .mosi_o(mosi2)
    );

    typedef struct {
        bit          sel;       // 0: CLK_DIV=4 instance, 1: CLK_DIV=2 instance
        logic [11:0] data;
        int          restart;   // cycle of a second start pulse, 0 = none
        logic [11:0] data2;
        int          tail;      // cycles observed after the done cycle
        logic [15:0] frame;
        int          done_at;
    } vec_t;

    vec_t vecs[6];

    // Shortest cs_n high interval seen on the H=4 instance between two frames.
    int gap4 = 1000;
    int run4 = 0;
    always @(negedge clk) begin
        if (cs4) begin
            run4++;
        end else begin
            if (run4 > 0 && run4 < gap4) gap4 = run4;
            run4 = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs(input bit sel);
        return sel ? {cs2, sclk2, mosi2, busy2, done2} : {cs4, sclk4, mosi4, busy4, done4};
    endfunction

    task automatic run_vec(input int i);
        int          h;
        int          limit;
        logic [15:0] frame;
        int          done_at, dcnt, bcnt, rises, hr, lr;
        bit          prev, run_ok, mosi_ok, tail_ok;
        logic [4:0]  o;
        h       = vecs[i].sel ? 2 : 4;
        limit   = 34 * h + 1 + vecs[i].tail;
        frame   = 16'h0;
        done_at = -1; dcnt = 0; bcnt = 0; rises = 0; hr = 0; lr = 0;
        prev    = 1'b0; run_ok = 1'b1; mosi_ok = 1'b1; tail_ok = 1'b1;
        data_i  = vecs[i].data;
        if (vecs[i].sel) start2 = 1'b1; else start4 = 1'b1;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            o = outs(vecs[i].sel);   // {cs, sclk, mosi, busy, done}
            if (o[0]) begin dcnt++; done_at = cyc; end
            if (o[1]) bcnt++;
            if (o[4] && o[2]) mosi_ok = 1'b0;
            if (cyc > 34 * h + 1 && !o[4]) tail_ok = 1'b0;
            if (o[3]) begin
                if (!prev) begin
                    if (rises < 16) frame[15 - rises] = o[2];
                    if (rises > 0 && lr != h) run_ok = 1'b0;
                    rises++;
                    lr = 0;
                end
                hr++;
            end else begin
                if (prev && hr != h) run_ok = 1'b0;
                hr = 0;
                if (!o[4]) lr++;
            end
            prev = o[3];
            if (vecs[i].sel) start2 = (cyc == vecs[i].restart);
            else             start4 = (cyc == vecs[i].restart);
            data_i = (cyc == vecs[i].restart) ? vecs[i].data2 : ~vecs[i].data;
        end
        chk($sformatf("v%0d frame", i), 32'(frame), 32'(vecs[i].frame));
        chk($sformatf("v%0d done_at", i), 32'(done_at), 32'(vecs[i].done_at));
        chk($sformatf("v%0d done_count", i), 32'(dcnt), 32'd1);
        chk($sformatf("v%0d busy_cycles", i), 32'(bcnt), 32'(vecs[i].done_at));
        chk($sformatf("v%0d sclk_rises", i), 32'(rises), 32'd16);
        chk($sformatf("v%0d sclk_phase", i), 32'(run_ok), 32'd1);
        chk($sformatf("v%0d mosi_idle", i), 32'(mosi_ok), 32'd1);
        chk($sformatf("v%0d cs_tail", i), 32'(tail_ok), 32'd1);
        $display("vec %0d sel=%0d data=%h frame=%h done_at=%0d", i, vecs[i].sel,
                 vecs[i].data, frame, done_at);
    endtask

    initial begin
        int dcnt;
        int cslow;
        vecs[0] = '{sel: 1'b0, data: 12'h4D8, restart: 0,  data2: 12'h000, tail: 8, frame: 16'h74D8, done_at: 137};
        vecs[1] = '{sel: 1'b0, data: 12'hE88, restart: 0,  data2: 12'h000, tail: 1, frame: 16'h7E88, done_at: 137};
        vecs[2] = '{sel: 1'b0, data: 12'h000, restart: 0,  data2: 12'h000, tail: 8, frame: 16'h7000, done_at: 137};
        vecs[3] = '{sel: 1'b0, data: 12'h4D8, restart: 50, data2: 12'hFFF, tail: 8, frame: 16'h74D8, done_at: 137};
        vecs[4] = '{sel: 1'b1, data: 12'hAAA, restart: 0,  data2: 12'h000, tail: 8, frame: 16'h7AAA, done_at: 69};
        vecs[5] = '{sel: 1'b1, data: 12'h555, restart: 0,  data2: 12'h000, tail: 8, frame: 16'h7555, done_at: 69};

        repeat (3) @(negedge clk);
        chk("reset_outs_h4", 32'(outs(1'b0)), 32'b10000);
        chk("reset_outs_h2", 32'(outs(1'b1)), 32'b10000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_vec(0);
        gap4 = 1000;
        run_vec(1);
        run_vec(2);
        chk("cs_gap_between_frames", 32'(gap4 >= 2), 32'd1);
        $display("back-to-back min cs_n high gap = %0d", gap4);
        run_vec(3);

        // Reset in the middle of a frame.
        data_i = 12'h4D8;
        start4 = 1'b1;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge clk);
            start4 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outs", 32'(outs(1'b0)), 32'b10000);
        rst = 1'b0;
        dcnt = 0; cslow = 0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(negedge clk);
            if (done4) dcnt++;
            if (!cs4) cslow++;
        end
        chk("midreset_no_done", 32'(dcnt), 32'd0);
        chk("midreset_cs_idle", 32'(cslow), 32'd0);
        $display("mid-frame reset: done pulses=%0d cs low cycles=%0d", dcnt, cslow);
        run_vec(0);

        // Start and reset on the same edge.
        start4 = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        chk("collide_outs", 32'(outs(1'b0)), 32'b10000);
        start4 = 1'b0;
        rst    = 1'b0;
        cslow  = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (!cs4 || busy4) cslow++;
        end
        chk("collide_no_frame", 32'(cslow), 32'd0);
        $display("start+reset collision: active cycles=%0d", cslow);

        run_vec(4);
        run_vec(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in clk_i cycles (legal range 2..255).
REQ-002 The module SHALL have parameter CFG_BITS, default 4'b0111, giving the 4 DAC control bits (A/B=0, BUF=1, GA_n=1, SHDN_n=1) sent ahead of the data.
REQ-003 clk_i  input  1  system clock; all logic is on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 start_i  input  1  one-cycle request to transmit data_i.
REQ-006 data_i  input  12  DAC code from the voltage lookup table.
REQ-007 busy_o  output  1  high while a frame is in progress.
REQ-008 done_o  output  1  one-cycle pulse at the end of a frame.
REQ-009 cs_n_o  output  1  DAC chip select, active-low.
REQ-010 sclk_o  output  1  SPI clock, mode 0 (idle low).
REQ-011 mosi_o  output  1  serial data, MSB first.

Function
REQ-012 The module SHALL use FSM states IDLE, SETUP, SHIFT, HOLD and DONE; let H = CLK_DIV.
REQ-013 In IDLE, the module SHALL sample start_i; when start_i=1 it SHALL latch the frame {CFG_BITS, data_i} into a 16-bit shift register and enter SETUP on the next edge.
REQ-014 The module SHALL ignore start_i in every state other than IDLE, without queuing the request or corrupting the latched frame.
REQ-015 In SETUP, for H cycles, the module SHALL hold cs_n_o=0, sclk_o=0 and mosi_o=frame bit 15.
REQ-016 In SHIFT, the module SHALL toggle sclk_o every H cycles, producing 16 rising edges over 32H cycles.
REQ-017 In SHIFT, the module SHALL update mosi_o to the next bit only on the cycle in which sclk_o falls, so that each bit is stable for H cycles on either side of its rising edge.
REQ-018 After the 16th falling edge (sclk_o=0), the module SHALL enter HOLD for H cycles with cs_n_o=0 and sclk_o=0.
REQ-019 In DONE, which lasts one cycle, the module SHALL drive cs_n_o=1 and done_o=1, then return to IDLE.
REQ-020 The module SHALL assert done_o exactly 34H+1 cycles after the edge that sampled start_i (137 cycles for H=4).
REQ-021 The module SHALL hold busy_o=1 from the SETUP entry cycle through the DONE cycle inclusive, and 0 otherwise.
REQ-022 Because start_i is accepted only in IDLE, the module SHALL keep cs_n_o high for at least 2 cycles between frames.
REQ-023 The module SHALL count bits with a 5-bit counter and the half-period with an 8-bit counter; each counter SHALL reset to 0 on every state entry, with no wrap-around past its terminal value.
REQ-024 The module SHALL drive mosi_o=0 whenever cs_n_o=1.
REQ-025 The module SHALL drive all outputs from registers, with no combinational path from an input to an output.

Reset
REQ-026 When rst_i=1 on a clock edge, the module SHALL force the following on the next cycle, in any state, including mid-frame: state=IDLE, cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, counters=0, shift register=0.
REQ-027 The module SHALL NOT emit a done_o pulse for a frame aborted by reset.
REQ-028 If start_i and rst_i are both high on the same edge, reset SHALL take priority and the frame SHALL NOT start.

Structure
REQ-029 The FSM state encoding, frame width (16) and the CFG_BITS default SHALL live in the shared package dac_adc_pkg.
REQ-030 Half-period timing SHALL be implemented in one sub-module, spi_clk_en, which produces a one-cycle tick every CLK_DIV cycles while enabled and restarts its count when re-enabled; all other logic SHALL be inline.

Verification
REQ-031 Basic frame: H=4, data_i=12'h4D8 (1.00 V) with a start pulse -> sampling MOSI on 16 SCLK rising edges gives 16'h74D8; done_o pulses at cycle 137; busy_o is high for 137 cycles.
REQ-032 Full-scale code: data_i=12'hE88 (3.00 V), then data_i=12'h000 -> captured frames 16'h7E88 and 16'h7000; cs_n_o is high for at least 2 cycles between the frames.
REQ-033 Start while busy: start_i pulsed again at cycle 50 with data_i=12'hFFF -> the frame is unchanged (16'h74D8), exactly one done_o pulse occurs, and no second frame is sent.
REQ-034 Reset mid-frame: rst_i asserted at cycle 70 -> on the next cycle cs_n_o=1, sclk_o=0, busy_o=0; no done_o pulse; a subsequent start sends a complete correct frame.
REQ-035 Divider corner: CLK_DIV=2, data_i=12'hAAA -> frame 16'h7AAA, each SCLK phase lasts 2 cycles, and done_o asserts at cycle 69.
REQ-036 Simultaneous start and reset on the same edge -> no frame starts and cs_n_o stays 1.
